// File: rtl/acia_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acia_pkg
// Brief    : Register map, status bit positions and FSM states for the
//            W65C51N-compatible UART front-end bridge.
// Revision : 1.0 - initial release
// ============================================================================
package acia_pkg;

    localparam logic [1:0] ACIA_REG_DATA   = 2'b00;
    localparam logic [1:0] ACIA_REG_STATUS = 2'b01;
    localparam logic [1:0] ACIA_REG_CMD    = 2'b10;
    localparam logic [1:0] ACIA_REG_CTL    = 2'b11;

    localparam int ACIA_ST_PE   = 0;
    localparam int ACIA_ST_FE   = 1;
    localparam int ACIA_ST_OVR  = 2;
    localparam int ACIA_ST_RDRF = 3;
    localparam int ACIA_ST_TDRE = 4;
    localparam int ACIA_ST_DCD  = 5;
    localparam int ACIA_ST_DSR  = 6;
    localparam int ACIA_ST_IRQ  = 7;

    typedef enum logic [3:0] {
        ST_INIT_CMD   = 4'd0,
        ST_INIT_CTL   = 4'd1,
        ST_GAP        = 4'd2,
        ST_RD_STAT    = 4'd3,
        ST_WAIT_STAT  = 4'd4,
        ST_DECIDE     = 4'd5,
        ST_RD_DATA    = 4'd6,
        ST_WAIT_DATA  = 4'd7,
        ST_WR_DATA    = 4'd8
    } bridge_state_t;

endpackage : acia_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count and combinational head.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign w_do_pop  = pop & (r_level != '0);
    assign w_do_push = push & ((r_level != c_full) | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_level == '0);
    assign full  = (r_level == c_full);
    assign level = r_level;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/acia_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : acia_fifo_bridge
// Brief    : Polls a W65C51N-compatible UART as bus master, draining a TX
//            FIFO into it and collecting received bytes into an RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module acia_fifo_bridge
    import acia_pkg::*;
#(
    parameter int         TX_DEPTH = 16,
    parameter int         RX_DEPTH = 16,
    parameter int         POLL_GAP = 4,
    parameter logic [7:0] CMD_INIT = 8'h0B,
    parameter logic [7:0] CTL_INIT = 8'h1E
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [7:0]                  rx_data,
    output logic [2:0]                  rx_err,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        uart_cs,
    output logic                        uart_rw,
    output logic [1:0]                  uart_rs,
    output logic [7:0]                  uart_wdata,
    input  logic [7:0]                  uart_rdata
);

    localparam logic [7:0] c_gap_last = 8'(POLL_GAP - 1);

    bridge_state_t r_state;
    bridge_state_t w_next_state;

    logic [4:0]  r_stat;
    logic [7:0]  r_gap_cnt;
    logic        r_init_done;
    logic        r_uart_cs;
    logic        r_uart_rw;
    logic [1:0]  r_uart_rs;
    logic [7:0]  r_uart_wdata;

    logic        w_bus_cs;
    logic        w_bus_rw;
    logic [1:0]  w_bus_rs;
    logic [7:0]  w_bus_wdata;

    logic        w_tx_push;
    logic        w_tx_pop;
    logic [7:0]  w_tx_head;
    logic        w_tx_empty;
    logic        w_tx_full;

    logic        w_rx_push;
    logic [10:0] w_rx_head;
    logic        w_rx_empty;
    logic        w_rx_full;

    assign tx_ready  = r_init_done & ~w_tx_full;
    assign w_tx_push = tx_valid & tx_ready;
    assign w_rx_push = (r_state == ST_WAIT_DATA);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (tx_data),
        .pop       (w_tx_pop),
        .head      (w_tx_head),
        .empty     (w_tx_empty),
        .full      (w_tx_full),
        .level     (tx_level)
    );

    sync_fifo #(
        .WIDTH (11),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_rx_push),
        .push_data ({r_stat[2:0], uart_rdata}),
        .pop       (rx_ready),
        .head      (w_rx_head),
        .empty     (w_rx_empty),
        .full      (w_rx_full),
        .level     (rx_level)
    );

    assign {rx_err, rx_data} = w_rx_head;
    assign rx_valid          = ~w_rx_empty;

    // Bus signals are registered from the next state, so each access is on
    // the pins during the cycle the FSM sits in the matching state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT_CMD:  if (r_uart_cs) w_next_state = ST_INIT_CTL;
            ST_INIT_CTL:  w_next_state = ST_GAP;
            ST_GAP:       if (r_gap_cnt == c_gap_last) w_next_state = ST_RD_STAT;
            ST_RD_STAT:   w_next_state = ST_WAIT_STAT;
            ST_WAIT_STAT: w_next_state = ST_DECIDE;
            ST_DECIDE: begin
                if (r_stat[ACIA_ST_RDRF] && !w_rx_full) begin
                    w_next_state = ST_RD_DATA;
                end else if (r_stat[ACIA_ST_TDRE] && !w_tx_empty) begin
                    w_next_state = ST_WR_DATA;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            ST_RD_DATA:   w_next_state = ST_WAIT_DATA;
            ST_WAIT_DATA: w_next_state = ST_GAP;
            ST_WR_DATA:   w_next_state = ST_GAP;
            default:      w_next_state = ST_INIT_CMD;
        endcase
    end

    always_comb begin
        w_bus_cs    = 1'b0;
        w_bus_rw    = 1'b1;
        w_bus_rs    = r_uart_rs;
        w_bus_wdata = r_uart_wdata;
        w_tx_pop    = 1'b0;
        case (w_next_state)
            ST_INIT_CMD: begin
                w_bus_cs    = 1'b1;
                w_bus_rw    = 1'b0;
                w_bus_rs    = ACIA_REG_CMD;
                w_bus_wdata = CMD_INIT;
            end
            ST_INIT_CTL: begin
                w_bus_cs    = 1'b1;
                w_bus_rw    = 1'b0;
                w_bus_rs    = ACIA_REG_CTL;
                w_bus_wdata = CTL_INIT;
            end
            ST_RD_STAT: begin
                w_bus_cs = 1'b1;
                w_bus_rs = ACIA_REG_STATUS;
            end
            ST_RD_DATA: begin
                w_bus_cs = 1'b1;
                w_bus_rs = ACIA_REG_DATA;
            end
            ST_WR_DATA: begin
                w_bus_cs    = 1'b1;
                w_bus_rw    = 1'b0;
                w_bus_rs    = ACIA_REG_DATA;
                w_bus_wdata = w_tx_head;
                w_tx_pop    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT_CMD;
            r_stat       <= '0;
            r_gap_cnt    <= '0;
            r_init_done  <= 1'b0;
            r_uart_cs    <= 1'b0;
            r_uart_rw    <= 1'b1;
            r_uart_rs    <= 2'b00;
            r_uart_wdata <= 8'h00;
        end else begin
            r_state      <= w_next_state;
            r_uart_cs    <= w_bus_cs;
            r_uart_rw    <= w_bus_rw;
            r_uart_rs    <= w_bus_rs;
            r_uart_wdata <= w_bus_wdata;
            if (r_state == ST_WAIT_STAT) begin
                r_stat <= uart_rdata[4:0];
            end
            if (r_state == ST_INIT_CTL) begin
                r_init_done <= 1'b1;
            end
            if (r_state == ST_GAP && w_next_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign uart_cs    = r_uart_cs;
    assign uart_rw    = r_uart_rw;
    assign uart_rs    = r_uart_rs;
    assign uart_wdata = r_uart_wdata;

endmodule : acia_fifo_bridge
`default_nettype wire

// File: tb/tb_acia_fifo_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_acia_fifo_bridge
// Brief    : Self-checking bench with a behavioural UART register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acia_fifo_bridge;
    import acia_pkg::*;

    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;
    localparam int POLL_GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic [2:0]  rx_err;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;
    logic        uart_cs;
    logic        uart_rw;
    logic [1:0]  uart_rs;
    logic [7:0]  uart_wdata;
    logic [7:0]  uart_rdata = 8'h00;

    always #5 clk = ~clk;

    acia_fifo_bridge #(
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH),
        .POLL_GAP (POLL_GAP),
        .CMD_INIT (8'h0B),
        .CTL_INIT (8'h1E)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_level   (tx_level),
        .rx_level   (rx_level),
        .uart_cs    (uart_cs),
        .uart_rw    (uart_rw),
        .uart_rs    (uart_rs),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART register model: pending receive bytes carry their own error bits.
    logic        tdre = 1'b0;
    logic [10:0] urxq[$];
    logic [10:0] exp_rx[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  last_stat = 8'h00;

    function automatic logic [7:0] stat_now();
        logic [2:0] e;
        e = (urxq.size() != 0) ? urxq[0][10:8] : 3'b000;
        return {3'b000, tdre, (urxq.size() != 0), e};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            uart_rdata <= 8'h00;
            exp_rx.delete();
        end else if (uart_cs && uart_rw) begin
            if (uart_rs == ACIA_REG_STATUS) begin
                uart_rdata <= stat_now();
                last_stat  <= stat_now();
            end else if (uart_rs == ACIA_REG_DATA && urxq.size() != 0) begin
                uart_rdata <= urxq[0][7:0];
                exp_rx.push_back({last_stat[2:0], urxq[0][7:0]});
                void'(urxq.pop_front());
            end else begin
                uart_rdata <= 8'h00;
            end
        end
    end

    // Bus and stream checker against the model.
    logic [10:0] log_q[$];
    logic [10:0] head_exp;
    int  n_rd = 0;
    int  n_wr = 0;
    int  last_rd_cyc = 0;
    int  last_wr_cyc = -1000;
    bit  data_this_poll = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            log_q.delete();
            data_this_poll = 1'b0;
            last_wr_cyc    = -1000;
        end else begin
            if (uart_cs) begin
                log_q.push_back({uart_rw, uart_rs, (uart_rw ? 8'h00 : uart_wdata)});
                if (uart_rw && uart_rs == ACIA_REG_STATUS) data_this_poll = 1'b0;
                if (uart_rs == ACIA_REG_DATA) begin
                    chk("one_data_access_per_poll", data_this_poll, 0);
                    data_this_poll = 1'b1;
                    if (uart_rw) begin
                        chk("read_needs_rdrf", last_stat[3], 1);
                        n_rd++;
                        last_rd_cyc = cyc;
                    end else begin
                        chk("write_needs_tdre", last_stat[4], 1);
                        chk("rx_has_priority", last_stat[3] && (exp_rx.size() < RX_DEPTH), 0);
                        chk("tx_model_nonempty", exp_tx.size() != 0, 1);
                        if (exp_tx.size() != 0) chk("tx_order", uart_wdata, exp_tx.pop_front());
                        chk("tx_spacing", (cyc - last_wr_cyc) >= POLL_GAP + 4, 1);
                        last_wr_cyc = cyc;
                        n_wr++;
                    end
                end
            end
            chk("tx_level", tx_level, exp_tx.size());
            if (rx_valid) begin
                chk("rx_model_nonempty", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) begin
                    head_exp = exp_rx[0];
                    chk("rx_head_data", rx_data, head_exp[7:0]);
                    chk("rx_head_err", rx_err, head_exp[10:8]);
                    if (rx_ready) void'(exp_rx.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        logic ok;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !tx_ready; i++) step();
        ok = tx_ready;
        chk("tx_ready_wait", ok, 1);
        step();
        if (ok) exp_tx.push_back(b);
        tx_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] d, input logic [2:0] e);
        for (int i = 0; i < 300 && !rx_valid; i++) step();
        chk("rx_valid_wait", rx_valid, 1);
        chk("rx_data_literal", rx_data, d);
        chk("rx_err_literal", rx_err, e);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic check_init();
        for (int i = 0; i < 100 && log_q.size() < 3; i++) step();
        chk("init_log_len", log_q.size() >= 3, 1);
        if (log_q.size() >= 3) begin
            chk("init_cmd_write", log_q[0], 11'h20B);
            chk("init_ctl_write", log_q[1], 11'h31E);
            chk("first_status_read", log_q[2], 11'h500);
        end
        chk("tx_ready_after_init", tx_ready, 1);
    endtask

    initial begin
        int b;
        int brd;

        // Reset state
        step(); step();
        chk("rst_uart_cs", uart_cs, 0);
        chk("rst_uart_rw", uart_rw, 1);
        chk("rst_uart_rs", uart_rs, 0);
        chk("rst_uart_wdata", uart_wdata, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        rst = 1'b0;
        check_init();

        // TX drain in order
        push_tx(8'h41);
        push_tx(8'h42);
        push_tx(8'h43);
        chk("tx_level_three", tx_level, 3);
        b = n_wr;
        tdre = 1'b1;
        for (int i = 0; i < 300 && (n_wr - b) < 3; i++) step();
        chk("tx_three_writes", n_wr - b, 3);
        chk("tx_level_zero", tx_level, 0);
        tdre = 1'b0;

        // Single receive byte, status 0x08
        b = n_rd;
        urxq.push_back({3'b000, 8'h5A});
        for (int i = 0; i < 300 && !rx_valid; i++) step();
        repeat (40) step();
        chk("single_data_read", n_rd - b, 1);
        pop_expect(8'h5A, 3'b000);

        // Status 0x1C: read before write
        push_tx(8'h55);
        brd = n_rd;
        b   = n_wr;
        urxq.push_back({3'b100, 8'h66});
        tdre = 1'b1;
        for (int i = 0; i < 300 && n_wr == b; i++) step();
        chk("prio_write_done", n_wr - b, 1);
        chk("prio_read_done", n_rd - brd, 1);
        chk("prio_read_first", last_rd_cyc < last_wr_cyc, 1);
        tdre = 1'b0;
        pop_expect(8'h66, 3'b100);

        // RX FIFO fill and backpressure
        b = n_rd;
        for (int i = 0; i < 16; i++) urxq.push_back({3'b000, 8'h80 + 8'(i)});
        urxq.push_back({3'b100, 8'h90});
        for (int i = 0; i < 600 && rx_level != 5'd16; i++) step();
        chk("rx_level_full", rx_level, 16);
        repeat (40) step();
        chk("no_read_while_full", n_rd - b, 16);
        chk("byte_left_in_uart", urxq.size(), 1);
        pop_expect(8'h80, 3'b000);
        for (int i = 0; i < 12 && (n_rd - b) < 17; i++) step();
        chk("read_after_pop", n_rd - b, 17);
        for (int i = 1; i < 16; i++) pop_expect(8'h80 + 8'(i), 3'b000);
        pop_expect(8'h90, 3'b100);

        // Reset while waiting on a data read
        push_tx(8'hC1);
        push_tx(8'hC2);
        urxq.push_back({3'b000, 8'hA0});
        urxq.push_back({3'b000, 8'hA1});
        urxq.push_back({3'b000, 8'hA2});
        for (int i = 0; i < 300 && rx_level == 5'd0; i++) step();
        for (int i = 0; i < 100 && !(uart_cs && uart_rw && uart_rs == ACIA_REG_DATA); i++) step();
        chk("found_data_read", uart_cs && uart_rw && uart_rs == ACIA_REG_DATA, 1);
        step();
        chk("pre_rst_rx_level", rx_level, 1);
        chk("pre_rst_tx_level", tx_level, 2);
        rst = 1'b1;
        exp_tx.delete();
        step();
        chk("mid_rst_rx_level", rx_level, 0);
        chk("mid_rst_tx_level", tx_level, 0);
        chk("mid_rst_tx_ready", tx_ready, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_uart_cs", uart_cs, 0);
        step();
        rst = 1'b0;
        check_init();
        pop_expect(8'hA2, 3'b000);
        repeat (20) step();
        chk("rx_model_drained", exp_rx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_acia_fifo_bridge
`default_nettype wire
